// File: rtl/cve2_fetch_req_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : cve2_fetch_req_ctrl_pkg
// Brief   : Shared types and helpers for the instruction fetch request path.
// Rev     : 1.0  initial release
// ============================================================================
package cve2_fetch_req_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE          = 2'd0,
    FETCH_WAIT_GNT      = 2'd1,
    FETCH_WAIT_GNT_DISC = 2'd2
  } fetch_req_state_e;

  localparam logic [31:0] c_word_bytes = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cve2_fetch_req_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : cve2_fetch_req_ctrl_if
// Brief     : OBI-style instruction bus between fetch controller and memory.
// Rev       : 1.0  initial release
// ============================================================================
interface cve2_fetch_req_ctrl_if;

  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;

  modport master (
    output instr_req_o,
    output instr_addr_o,
    input  instr_gnt_i,
    input  instr_rvalid_i,
    input  instr_rdata_i,
    input  instr_err_i
  );

  modport slave (
    input  instr_req_o,
    input  instr_addr_o,
    output instr_gnt_i,
    output instr_rvalid_i,
    output instr_rdata_i,
    output instr_err_i
  );

endinterface
`default_nettype wire

// File: rtl/cve2_fetch_outstanding_ctr.sv
`default_nettype none
// ============================================================================
// Module : cve2_fetch_outstanding_ctr
// Brief  : Saturating outstanding/discard counter pair with load on branch.
// Rev    : 1.0  initial release
// ============================================================================
module cve2_fetch_outstanding_ctr #(
  parameter int unsigned NUM_REQS = 2,
  parameter int unsigned CNT_W    = $clog2(NUM_REQS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             disc_inc_i,
  input  logic             disc_dec_i,
  input  logic             load_i,
  input  logic             load_excl_i,
  output logic [CNT_W-1:0] outstanding_o,
  output logic [CNT_W-1:0] discard_o
);

  localparam logic [CNT_W-1:0] c_max = CNT_W'(NUM_REQS);
  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_discard;
  logic [CNT_W-1:0] w_outstanding_next;
  logic [CNT_W-1:0] w_discard_next;

  always_comb begin
    w_outstanding_next = r_outstanding;
    if (inc_i && !dec_i && (r_outstanding != c_max)) begin
      w_outstanding_next = r_outstanding + c_one;
    end else if (!inc_i && dec_i && (r_outstanding != '0)) begin
      w_outstanding_next = r_outstanding - c_one;
    end

    w_discard_next = r_discard;
    if (load_i) begin
      // A grant on the fast path belongs to the new target and must survive.
      if (load_excl_i && (w_outstanding_next != '0)) begin
        w_discard_next = w_outstanding_next - c_one;
      end else if (load_excl_i) begin
        w_discard_next = '0;
      end else begin
        w_discard_next = w_outstanding_next;
      end
    end else if (disc_inc_i && !disc_dec_i && (r_discard != c_max)) begin
      w_discard_next = r_discard + c_one;
    end else if (!disc_inc_i && disc_dec_i && (r_discard != '0)) begin
      w_discard_next = r_discard - c_one;
    end

    if (w_discard_next > w_outstanding_next) begin
      w_discard_next = w_outstanding_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      r_discard     <= w_discard_next;
    end
  end

  assign outstanding_o = r_outstanding;
  assign discard_o     = r_discard;

endmodule
`default_nettype wire

// File: rtl/cve2_fetch_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module : cve2_fetch_req_ctrl
// Brief  : Issues word-aligned fetches, tracks responses, filters stale data.
// Rev    : 1.0  initial release
// ============================================================================
module cve2_fetch_req_ctrl
  import cve2_fetch_req_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_clear_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                busy_o,
  cve2_fetch_req_ctrl_if.master bus
);

  localparam int unsigned c_cnt_w = $clog2(NUM_REQS + 1);
  localparam int unsigned c_sum_w = c_cnt_w + 1;

  fetch_req_state_e r_state;
  fetch_req_state_e w_state_next;

  logic [31:0]        r_fetch_addr;
  logic [31:0]        r_hold_addr;
  logic [31:0]        w_branch_addr;
  logic [31:0]        w_instr_addr;
  logic               w_instr_req;
  logic               w_can_issue;
  logic               w_gnt;
  logic               w_fast_gnt;
  logic               w_gnt_disc;
  logic               w_disc_dec;
  logic [c_cnt_w-1:0] w_outstanding;
  logic [c_cnt_w-1:0] w_discard;
  logic [c_sum_w-1:0] w_busy_cnt;
  logic [c_sum_w-1:0] w_live_cnt;

  assign w_branch_addr = word_align(addr_i);

  always_comb begin
    w_busy_cnt = '0;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      w_busy_cnt = w_busy_cnt + c_sum_w'(fifo_busy_i[i]);
    end
  end

  // Live responses plus FIFO occupancy must leave room for one more word.
  assign w_live_cnt  = c_sum_w'(w_outstanding) - c_sum_w'(w_discard) + w_busy_cnt;
  assign w_can_issue = req_i
                     & (w_outstanding < c_cnt_w'(NUM_REQS))
                     & (branch_i | (w_live_cnt < c_sum_w'(NUM_REQS)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= FETCH_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH_IDLE: begin
        if (w_can_issue && !bus.instr_gnt_i) begin
          w_state_next = FETCH_WAIT_GNT;
        end
      end
      FETCH_WAIT_GNT: begin
        if (bus.instr_gnt_i) begin
          w_state_next = FETCH_IDLE;
        end else if (branch_i) begin
          w_state_next = FETCH_WAIT_GNT_DISC;
        end
      end
      FETCH_WAIT_GNT_DISC: begin
        if (bus.instr_gnt_i) begin
          w_state_next = FETCH_IDLE;
        end
      end
      default: w_state_next = FETCH_IDLE;
    endcase
  end

  always_comb begin
    w_instr_req  = 1'b0;
    w_instr_addr = r_hold_addr;
    case (r_state)
      FETCH_IDLE: begin
        w_instr_req  = w_can_issue;
        w_instr_addr = branch_i ? w_branch_addr : r_fetch_addr;
      end
      FETCH_WAIT_GNT, FETCH_WAIT_GNT_DISC: begin
        w_instr_req = 1'b1;
      end
      default: w_instr_req = 1'b0;
    endcase
  end

  assign w_gnt      = w_instr_req & bus.instr_gnt_i;
  assign w_fast_gnt = (r_state == FETCH_IDLE) & w_gnt;
  assign w_gnt_disc = w_gnt & ((r_state == FETCH_WAIT_GNT_DISC)
                             | ((r_state == FETCH_WAIT_GNT) & branch_i));

  // While a stale request waits for its grant, fetch_addr keeps the target.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fetch_addr <= '0;
      r_hold_addr  <= '0;
    end else begin
      case (r_state)
        FETCH_IDLE: begin
          if (w_gnt) begin
            r_fetch_addr <= w_instr_addr + c_word_bytes;
          end else if (branch_i) begin
            r_fetch_addr <= w_branch_addr;
          end
          if (w_instr_req && !bus.instr_gnt_i) begin
            r_hold_addr <= w_instr_addr;
          end
        end
        FETCH_WAIT_GNT: begin
          if (branch_i) begin
            r_fetch_addr <= w_branch_addr;
          end else if (w_gnt) begin
            r_fetch_addr <= r_hold_addr + c_word_bytes;
          end
        end
        FETCH_WAIT_GNT_DISC: begin
          if (branch_i) begin
            r_fetch_addr <= w_branch_addr;
          end
        end
        default: r_fetch_addr <= r_fetch_addr;
      endcase
    end
  end

  assign w_disc_dec = bus.instr_rvalid_i & (w_discard != '0);

  cve2_fetch_outstanding_ctr #(
    .NUM_REQS (NUM_REQS),
    .CNT_W    (c_cnt_w)
  ) u_outstanding_ctr (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .inc_i         (w_gnt),
    .dec_i         (bus.instr_rvalid_i),
    .disc_inc_i    (w_gnt_disc),
    .disc_dec_i    (w_disc_dec),
    .load_i        (branch_i),
    .load_excl_i   (w_fast_gnt),
    .outstanding_o (w_outstanding),
    .discard_o     (w_discard)
  );

  assign bus.instr_req_o  = w_instr_req;
  assign bus.instr_addr_o = w_instr_addr;

  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  assign fifo_rdata_o = bus.instr_rdata_i;
  assign fifo_err_o   = bus.instr_err_i;
  assign fifo_valid_o = bus.instr_rvalid_i & (w_discard == '0) & ~branch_i;
  assign busy_o       = (w_outstanding != '0) | w_instr_req;

  a_outstanding_max : assert property (@(posedge clk_i) disable iff (rst_i)
    w_outstanding <= c_cnt_w'(NUM_REQS));

  a_addr_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    ($past(w_instr_req & ~bus.instr_gnt_i) && !$past(rst_i))
      |-> (w_instr_addr == $past(w_instr_addr)));

  a_no_push_full : assert property (@(posedge clk_i) disable iff (rst_i)
    fifo_valid_o |-> !fifo_busy_i[NUM_REQS-1]);

  a_rvalid_legal : assert property (@(posedge clk_i) disable iff (rst_i)
    bus.instr_rvalid_i |-> (w_outstanding != '0));

endmodule
`default_nettype wire

// File: tb/tb_cve2_fetch_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_cve2_fetch_req_ctrl
// Brief  : Directed + random bench against a queue-level fetch reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cve2_fetch_req_ctrl;

  localparam int N = 2;

  logic          clk;
  logic          rst;
  logic          req_i;
  logic          branch_i;
  logic [31:0]   addr_i;
  logic [N-1:0]  fifo_busy_i;
  logic          fifo_clear_o;
  logic          fifo_valid_o;
  logic [31:0]   fifo_addr_o;
  logic [31:0]   fifo_rdata_o;
  logic          fifo_err_o;
  logic          busy_o;

  cve2_fetch_req_ctrl_if bus ();

  cve2_fetch_req_ctrl #(.NUM_REQS(N)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req_i),
    .branch_i     (branch_i),
    .addr_i       (addr_i),
    .fifo_busy_i  (fifo_busy_i),
    .fifo_clear_o (fifo_clear_o),
    .fifo_valid_o (fifo_valid_o),
    .fifo_addr_o  (fifo_addr_o),
    .fifo_rdata_o (fifo_rdata_o),
    .fifo_err_o   (fifo_err_o),
    .busy_o       (busy_o),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // stimulus intent
  bit          t_req, t_branch, t_gnt, t_rvalid, t_err, t_pop;
  logic [31:0] t_addr, t_rdata;

  // reference model: in-flight requests in issue order, a held request, FIFO fill
  logic [31:0] q_addr[$];
  bit          q_drop[$];
  logic [31:0] m_fetch, m_hold;
  bit          m_hold_v, m_hold_drop;
  int          fifo_cnt;

  bit          rv_eff, exp_req, exp_valid, exp_busy;
  logic [31:0] exp_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_addr.delete();
    q_drop.delete();
    m_fetch     = 32'h0;
    m_hold      = 32'h0;
    m_hold_v    = 1'b0;
    m_hold_drop = 1'b0;
    fifo_cnt    = 0;
  endtask

  task automatic apply();
    req_i    = t_req;
    branch_i = t_branch;
    addr_i   = t_addr;
    for (int i = 0; i < N; i++) fifo_busy_i[i] = (fifo_cnt > i + 1);
    rv_eff                = t_rvalid && (q_addr.size() > 0);
    bus.instr_gnt_i       = t_gnt;
    bus.instr_rvalid_i    = rv_eff;
    bus.instr_rdata_i     = t_rdata;
    bus.instr_err_i       = t_err;
  endtask

  task automatic model_check();
    int live;
    live = 0;
    foreach (q_drop[i]) if (!q_drop[i]) live++;
    if (m_hold_v) begin
      exp_req  = 1'b1;
      exp_addr = m_hold;
    end else begin
      exp_req  = t_req && (q_addr.size() < N) && (t_branch || (live + fifo_cnt - ((fifo_cnt > 0) ? 1 : 0) < N));
      exp_addr = t_branch ? {t_addr[31:2], 2'b00} : m_fetch;
    end
    exp_valid = rv_eff && !q_drop[0] && !t_branch;
    exp_busy  = (q_addr.size() != 0) || exp_req;
    chk("instr_req", bus.instr_req_o, exp_req);
    if (exp_req) chk("instr_addr", bus.instr_addr_o, exp_addr);
    chk("fifo_valid", fifo_valid_o, exp_valid);
    chk("fifo_clear", fifo_clear_o, t_branch);
    chk("busy", busy_o, exp_busy);
    if (exp_valid) begin
      chk("fifo_rdata", fifo_rdata_o, t_rdata);
      chk("fifo_err", fifo_err_o, t_err);
    end
    if (t_branch) chk("fifo_addr", fifo_addr_o, t_addr);
  endtask

  task automatic model_commit();
    bit          g;
    logic [31:0] tgt;
    g   = t_gnt && exp_req;
    tgt = {t_addr[31:2], 2'b00};
    if (rv_eff) begin
      void'(q_addr.pop_front());
      void'(q_drop.pop_front());
    end
    if (t_branch) foreach (q_drop[i]) q_drop[i] = 1'b1;
    if (m_hold_v) begin
      if (g) begin
        q_addr.push_back(m_hold);
        q_drop.push_back(m_hold_drop || t_branch);
        if (!t_branch && !m_hold_drop) m_fetch = m_hold + 32'd4;
        m_hold_v = 1'b0;
      end else if (t_branch) begin
        m_hold_drop = 1'b1;
      end
      if (t_branch) m_fetch = tgt;
    end else if (exp_req) begin
      if (g) begin
        q_addr.push_back(exp_addr);
        q_drop.push_back(1'b0);
        m_fetch = exp_addr + 32'd4;
      end else begin
        m_hold_v    = 1'b1;
        m_hold      = exp_addr;
        m_hold_drop = 1'b0;
        if (t_branch) m_fetch = tgt;
      end
    end else if (t_branch) begin
      m_fetch = tgt;
    end
    if (t_branch) fifo_cnt = 0;
    else fifo_cnt = fifo_cnt + (exp_valid ? 1 : 0) - ((t_pop && fifo_cnt > 0) ? 1 : 0);
  endtask

  task automatic settle();
    apply();
    #4;
    model_check();
  endtask

  task automatic commit();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    t_req = 0; t_branch = 0; t_addr = 0; t_gnt = 0;
    t_rvalid = 0; t_rdata = 0; t_err = 0; t_pop = 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    apply();
    #4;
    chk("rst_req", bus.instr_req_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_valid", fifo_valid_o, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_req_hold", bus.instr_req_o, 1'b0);
    rst = 1'b0;
  endtask

  task automatic drain();
    t_req = 0; t_branch = 0; t_gnt = 1; t_err = 0;
    for (int i = 0; i < 4; i++) begin
      t_rvalid = 1; t_rdata = $urandom;
      settle();
      commit();
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    apply();

    // sequential fetch after branch to 0x100
    do_reset();
    t_req = 1; t_branch = 1; t_addr = 32'h100; t_gnt = 1;
    settle(); chk("t1_addr0", bus.instr_addr_o, 32'h100); commit();
    t_branch = 0; t_rvalid = 1; t_rdata = 32'hA0;
    settle(); chk("t1_addr1", bus.instr_addr_o, 32'h104); chk("t1_push0", fifo_valid_o, 1'b1); commit();
    t_rdata = 32'hA1;
    settle(); chk("t1_addr2", bus.instr_addr_o, 32'h108); chk("t1_push1", fifo_rdata_o, 32'hA1); commit();
    drain();

    // grant withheld at 0x200, branch to 0x302 while waiting
    do_reset();
    t_req = 1; t_branch = 1; t_addr = 32'h200; t_gnt = 0;
    settle(); chk("t2_addr0", bus.instr_addr_o, 32'h200); commit();
    t_branch = 0;
    settle(); chk("t2_addr1", bus.instr_addr_o, 32'h200); commit();
    t_branch = 1; t_addr = 32'h302;
    settle(); chk("t2_addr2", bus.instr_addr_o, 32'h200); chk("t2_req2", bus.instr_req_o, 1'b1); commit();
    t_branch = 0; t_gnt = 1;
    settle(); chk("t2_addr3", bus.instr_addr_o, 32'h200); commit();
    t_gnt = 0; t_rvalid = 1; t_rdata = 32'hBAD;
    settle(); chk("t2_drop", fifo_valid_o, 1'b0); chk("t2_next", bus.instr_addr_o, 32'h300); commit();
    t_rvalid = 0; t_gnt = 1;
    settle(); commit();
    t_gnt = 0; t_rvalid = 1; t_rdata = 32'h300;
    settle(); chk("t2_push", fifo_valid_o, 1'b1); commit();
    drain();

    // outstanding limit with rvalid withheld
    do_reset();
    t_req = 1; t_gnt = 1;
    settle(); chk("t3_g0", bus.instr_req_o, 1'b1); commit();
    settle(); chk("t3_g1", bus.instr_req_o, 1'b1); commit();
    settle(); chk("t3_stall0", bus.instr_req_o, 1'b0); chk("t3_busy", busy_o, 1'b1); commit();
    settle(); chk("t3_stall1", bus.instr_req_o, 1'b0); commit();
    t_rvalid = 1; t_rdata = 32'h0;
    settle(); chk("t3_stall_rv", bus.instr_req_o, 1'b0); chk("t3_push", fifo_valid_o, 1'b1); commit();
    t_rvalid = 0;
    settle(); commit();

    // branch with two outstanding: both responses dropped, 0x40 kept
    t_branch = 1; t_addr = 32'h40;
    settle(); chk("t4_clear", fifo_clear_o, 1'b1); chk("t4_noreq", bus.instr_req_o, 1'b0); commit();
    t_branch = 0; t_rvalid = 1;
    settle(); chk("t4_drop0", fifo_valid_o, 1'b0); commit();
    settle(); chk("t4_drop1", fifo_valid_o, 1'b0); chk("t4_addr40", bus.instr_addr_o, 32'h40); commit();
    t_rdata = 32'h40;
    settle(); chk("t4_push40", fifo_valid_o, 1'b1); commit();
    drain();

    // bus error response still pushed, fetch continues
    do_reset();
    t_req = 1; t_branch = 1; t_addr = 32'h10; t_gnt = 1;
    settle(); commit();
    t_branch = 0; t_rvalid = 1; t_err = 1;
    settle(); chk("t5_valid", fifo_valid_o, 1'b1); chk("t5_err", fifo_err_o, 1'b1);
    chk("t5_next", bus.instr_addr_o, 32'h14); commit();
    drain();

    // reset while a request waits for grant with one outstanding
    do_reset();
    t_req = 1; t_branch = 1; t_addr = 32'h80; t_gnt = 1;
    settle(); commit();
    t_branch = 0; t_gnt = 0;
    settle(); chk("t6_wait", bus.instr_req_o, 1'b1); commit();
    do_reset();
    t_req = 1;
    settle(); chk("t6_addr0", bus.instr_addr_o, 32'h0); commit();

    // address wrap at the top of memory
    do_reset();
    t_req = 1; t_branch = 1; t_addr = 32'hFFFF_FFFE; t_gnt = 1;
    settle(); chk("t7_top", bus.instr_addr_o, 32'hFFFF_FFFC); commit();
    t_branch = 0;
    settle(); chk("t7_wrap", bus.instr_addr_o, 32'h0); commit();
    drain();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        t_req    = ($urandom_range(0, 3) != 0);
        t_branch = ($urandom_range(0, 9) == 0);
        t_addr   = $urandom & 32'hFFFF_FFFE;
        t_gnt    = $urandom_range(0, 1);
        t_rvalid = $urandom_range(0, 1);
        t_rdata  = $urandom;
        t_err    = ($urandom_range(0, 7) == 0);
        t_pop    = ($urandom_range(0, 2) != 0);
        settle();
        commit();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
